param_multicycle_processor: RTL

//  Parametrised next-generation multicycle processor: fetch from iin, execute over 2-4 cycles on one shared bus.

---
 rtl/param_multicycle_processor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/param_multicycle_processor.sv
// Parametrised multicycle processor: fetches an instruction from iin in T0, then executes it over
// one to three further cycles, moving every operand across a single shared bus.
module param_multicycle_processor #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned REG_BITS = 3
) (
  input  logic             clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [WIDTH-1:0] iin,
  output logic             Done,
  output logic [WIDTH-1:0] bus
);

  localparam int unsigned NREGS = 2 ** REG_BITS;
  localparam int unsigned SHW   = $clog2(WIDTH);

  localparam logic [3:0] OpMv   = 4'd0;
  localparam logic [3:0] OpMvi  = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpSll  = 4'd7;
  localparam logic [3:0] OpMvnz = 4'd8;

  typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    regs_q [NREGS];
  logic [WIDTH-1:0]    ir_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    g_q;
  logic                z_q;

  logic [3:0]          op;
  logic [REG_BITS-1:0] rx;
  logic [REG_BITS-1:0] ry;
  logic                is_alu;
  logic [WIDTH-1:0]    bus_mux;
  logic                done_mux;
  logic [WIDTH-1:0]    alu_res;
  logic                unused_ir;

  assign op        = ir_q[WIDTH-1 -: 4];
  assign rx        = ir_q[WIDTH-5 -: REG_BITS];
  assign ry        = ir_q[WIDTH-5-REG_BITS -: REG_BITS];
  assign is_alu    = (op >= OpAdd) && (op <= OpSll);
  // Low instruction bits below ry carry no meaning.
  assign unused_ir = ^ir_q;

  // Bus source and Done are decoded from the current state and opcode.
  always_comb begin
    bus_mux  = '0;
    done_mux = 1'b0;
    case (state_q)
      StT1: begin
        if (op == OpMv || op == OpMvnz) begin
          bus_mux  = regs_q[ry];
          done_mux = 1'b1;
        end else if (op == OpMvi) begin
          bus_mux  = iin;
          done_mux = 1'b1;
        end else if (is_alu) begin
          bus_mux  = regs_q[rx];
        end else begin
          done_mux = 1'b1;
        end
      end
      StT2: bus_mux = regs_q[ry];
      StT3: begin
        bus_mux  = g_q;
        done_mux = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a_q + bus_mux;
      OpSub:   alu_res = a_q - bus_mux;
      OpAnd:   alu_res = a_q & bus_mux;
      OpOr:    alu_res = a_q | bus_mux;
      OpXor:   alu_res = a_q ^ bus_mux;
      OpSll:   alu_res = a_q << bus_mux[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Reset overrides the outputs too, so an aborted instruction shows nothing on the bus.
  assign bus  = Resetn ? '0 : bus_mux;
  assign Done = Resetn ? 1'b0 : done_mux;

  always_ff @(posedge clock) begin
    if (Resetn) begin
      state_q <= StT0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StT0: begin
          if (Run) begin
            ir_q    <= iin;
            state_q <= StT1;
          end
        end
        StT1: begin
          state_q <= StT0;
          if (op == OpMv || op == OpMvi) begin
            regs_q[rx] <= bus_mux;
          end else if (op == OpMvnz) begin
            if (!z_q) regs_q[rx] <= bus_mux;
          end else if (is_alu) begin
            a_q     <= bus_mux;
            state_q <= StT2;
          end
        end
        StT2: begin
          g_q     <= alu_res;
          z_q     <= (alu_res == '0);
          state_q <= StT3;
        end
        StT3: begin
          regs_q[rx] <= g_q;
          state_q    <= StT0;
        end
        default: state_q <= StT0;
      endcase
    end
  end

endmodule
